pass_entry: RTL and testbench
=============================

PASS_ENTRY -- requirements
Module: pass_entry

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles between successive bit samples (500 ms at 100 MHz); legal range 2..2^26-1.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin an 8-bit code capture.
REQ-005 in  input  1  serial code bit from player switch/button, sampled once per tick.
REQ-006 code  input  8  expected pass code, latched when start is accepted.
REQ-007 LED  output  8  captured bits so far; newest bit in LED[0].
REQ-008 busy  output  1  high while a capture or check is in progress.
REQ-009 pass  output  1  level, high when last completed capture matched the latched code.
REQ-010 fail  output  1  level, high when last completed capture did not match.

Function
REQ-011 States: IDLE, SHIFT, CHECK, PASS, FAIL; exactly one active.
REQ-012 IDLE: busy=0, pass=0, fail=0; LED holds its value; start=1 -> SHIFT.
REQ-013 Start accepted (any state): next cycle LED=8'h00, tick counter=0, bit counter=0, code latched, state=SHIFT, pass=0, fail=0.
REQ-014 SHIFT: tick counter (26 bits) increments each cycle; when it equals TICK_DIV-1, it returns to 0 and LED <= {LED[6:0], in}, bit counter +1.
REQ-015 First sample taken on the TICK_DIV-th rising edge after the edge that accepts start; subsequent samples every TICK_DIV cycles.
REQ-016 The edge taking the 8th sample moves SHIFT -> CHECK; bit counter (4 bits) never exceeds 8.
REQ-017 CHECK lasts exactly one cycle: LED == latched code -> PASS, else -> FAIL.
REQ-018 PASS: pass=1, busy=0, LED held; remains until reset or start.
REQ-019 FAIL: fail=1, busy=0, LED held; remains until reset or start.
REQ-020 busy=1 in SHIFT and CHECK only; pass and fail never high simultaneously.
REQ-021 Start during SHIFT or CHECK aborts current capture and restarts per REQ-013; no pass/fail produced for aborted capture.
REQ-022 Changes on code after start accepted have no effect on current capture.
REQ-023 in is sampled only on tick edges; values between ticks are ignored.
REQ-024 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-025 reset=1 at a rising edge: state=IDLE, LED=8'h00, busy=0, pass=0, fail=0, tick and bit counters=0, latched code=8'h00.
REQ-026 reset has priority over start and over any in-progress tick/sample on the same edge.
REQ-027 reset asserted mid-SHIFT discards partial capture; no pass/fail pulse follows.

Verification (TICK_DIV=4)
REQ-028 Match: code=8'hA5, start pulse, in driven MSB-first 1,0,1,0,0,1,0,1 held per 4-cycle tick -> LED=8'hA5 after 32 cycles, busy high cycles 1..33, pass=1 from cycle 34, fail=0.
REQ-029 Mismatch: code=8'hA5, in stream gives 8'hA4 -> fail=1, pass=0, LED=8'hA4 held.
REQ-030 Sample timing: start at cycle 0, in toggles every cycle -> LED[0] updates only on cycles 4,8,...,32, taking in value present at those edges.
REQ-031 Restart: start again after 3 samples of a capture -> LED=8'h00 next cycle, 8 fresh samples required, single pass/fail outcome.
REQ-032 Reset mid-capture at sample 5 -> all outputs zero next cycle, state IDLE, no pass/fail thereafter without new start.
REQ-033 Code change: code switched 8'hA5 -> 8'h00 during SHIFT with stream 8'hA5 -> pass=1.

Source files
------------

// File: rtl/pass_entry.sv
// rtl/pass_entry.sv - serial 8-bit pass code entry: tick-paced bit capture, then compare against latched code
// Outputs are registered from the next-state decode so they change on the same edge as the FSM.
module pass_entry #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in,
  input  logic [7:0] code,
  output logic [7:0] LED,
  output logic       busy,
  output logic       pass,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

  state_t      state;
  state_t      state_next;
  logic [25:0] tick_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  code_q;
  logic        tick_hit;

  assign tick_hit = (state == S_SHIFT) && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start request wins over whatever the FSM was doing, including CHECK.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_IDLE;
      S_SHIFT: if (tick_hit && bit_cnt == 4'd7) state_next = S_CHECK;
      S_CHECK: state_next = (LED == code_q) ? S_PASS : S_FAIL;
      S_PASS:  state_next = S_PASS;
      S_FAIL:  state_next = S_FAIL;
      default: state_next = S_IDLE;
    endcase
    if (start) state_next = S_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      LED      <= 8'h00;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      code_q   <= 8'h00;
    end else if (start) begin
      LED      <= 8'h00;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      code_q   <= code;
    end else if (state == S_SHIFT) begin
      if (tick_hit) begin
        tick_cnt <= '0;
        LED      <= {LED[6:0], in};
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 26'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      busy <= (state_next == S_SHIFT) || (state_next == S_CHECK);
      pass <= (state_next == S_PASS);
      fail <= (state_next == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pass_entry.sv
// tb/tb_pass_entry.sv - scoreboard bench for pass_entry with TICK_DIV=4
// Stimulus queues every expected output change with its edge number; the monitor pops on each observed change.
module tb_pass_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_bit = 1'b0;
  logic [7:0] code = 8'h00;
  logic [7:0] LED;
  logic       busy;
  logic       pass;
  logic       fail;

  pass_entry #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in_bit),
    .code  (code),
    .LED   (LED),
    .busy  (busy),
    .pass  (pass),
    .fail  (fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [10:0] snap;
  } exp_t;

  exp_t        q[$];
  logic [10:0] last_exp = 11'h000;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_reset = 0;
  bit          final_req = 0;
  bit          mon_en = 0;
  logic [10:0] mon_prev = 11'h000;

  always @(posedge clk) cyc <= cyc + 1;

  // Single checking process: owns both counters.
  always @(negedge clk) begin
    logic [10:0] cur;
    exp_t e;
    cur = {LED, busy, pass, fail};
    if (chk_reset) begin
      checks++;
      if (cur !== 11'h000) begin
        errors++;
        $display("FAIL reset_state got=%h required=000", cur);
      end
      mon_prev  = cur;
      chk_reset = 0;
      mon_en    = 1;
    end else if (mon_en && cur !== mon_prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got={LED,busy,pass,fail}=%h", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.snap !== cur) begin
          errors++;
          $display("FAIL out_change got cyc=%0d out=%h required cyc=%0d out=%h",
                   cyc, cur, e.cyc, e.snap);
        end
      end
      mon_prev = cur;
    end
    if (final_req) begin
      final_req = 0;
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL missing_changes got=%0d pending required=0 (next cyc=%0d out=%h)",
                 q.size(), q[0].cyc, q[0].snap);
      end
      checks++;
      if (cur !== 11'h000) begin
        errors++;
        $display("FAIL final_idle got=%h required=000", cur);
      end
    end
  end

  task automatic push(input int c, input logic [7:0] l, input logic b, input logic p, input logic f);
    logic [10:0] s;
    s = {l, b, p, f};
    if (s !== last_exp) begin
      q.push_back('{cyc: c, snap: s});
      last_exp = s;
    end
  endtask

  // Drives one capture: start, then `in` for edges a+1..a+stop_at; sample k lands on edge a+4k.
  task automatic capture(input logic [7:0] cd, input logic [7:0] stream, input bit toggle,
                         input int stop_at, input int chg_at, input logic [7:0] chg_code);
    int         a;
    logic [7:0] led_m;
    @(negedge clk);
    code  = cd;
    start = 1'b1;
    a     = cyc + 1;
    led_m = 8'h00;
    push(a, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= stop_at; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == chg_at) code = chg_code;
      if (toggle) in_bit = ~j[0];
      else if (j <= 32) in_bit = stream[7 - (j - 1) / 4];
      else in_bit = 1'b0;
      if (j % 4 == 0 && j <= 32) begin
        led_m = {led_m[6:0], in_bit};
        push(a + j, led_m, 1'b1, 1'b0, 1'b0);
      end
      if (j == 33) push(a + 33, led_m, 1'b0, led_m == cd, led_m != cd);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk_reset = 1;

    capture(8'hA5, 8'hA5, 0, 33, 0, 8'h00);
    idle(5);
    capture(8'hA5, 8'hA4, 0, 33, 0, 8'h00);
    idle(5);
    capture(8'hFF, 8'h00, 1, 33, 0, 8'h00);
    idle(3);
    capture(8'hA5, 8'hA5, 0, 33, 10, 8'h00);
    idle(3);
    capture(8'h3C, 8'hF0, 0, 12, 0, 8'h00);
    capture(8'h3C, 8'h3C, 0, 33, 0, 8'h00);
    idle(3);
    capture(8'h5A, 8'h5A, 0, 20, 0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    push(cyc + 1, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(40);
    reset = 1'b1;
    start = 1'b1;
    code  = 8'hFF;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    idle(20);

    @(posedge clk);
    #1 final_req = 1;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
